// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// controller state encoding and branch funct3 codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  function automatic logic br_cond(
    input logic [2:0] f3,
    input logic       zero,
    input logic       lt
  );
    logic c;
    c = 1'b0;
    unique case (1'b1)
      (f3 == F3_BEQ): c = zero;
      (f3 == F3_BNE): c = !zero;
      (f3 == F3_BLT): c = lt;
      (f3 == F3_BGE): c = !lt;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Ports: clk, reset (async, active-high), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipe: load-use bubble, branch flush
// in MEM, data-memory wait with timeout to a sticky bus error.
// Ports: clk, reset (async, active-high); ID/EX/MEM hazard sources;
// dmem_req/dmem_ready handshake; per-stage write/flush controls and
// pc_src; status bus_error, stall_cycles, flush_count.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_lessThan,
  input  logic [3:0]       mem_funct,
  input  logic             mem_memRead,
  input  logic             mem_memWrite,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic mem_access;
  logic mem_stall;
  logic taken;
  logic load_use;
  logic live;
  logic stall_inc;
  logic unused_f3;

  assign unused_f3  = mem_funct[3];
  assign mem_access = mem_memRead | mem_memWrite;
  assign live       = (state_q != ERROR);
  assign mem_stall  = live & mem_access & !dmem_ready;
  assign taken      = mem_branch &
    br_cond(mem_funct[2:0], mem_zero, mem_lessThan);
  assign load_use   = ex_memRead & (ex_rd != 5'd0) &
    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WLAST)
            state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    dmem_req    = live & mem_access;
    if (!live) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
    // reset wins over everything so an in-flight access drops at once
    if (reset) begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      dmem_req    = 1'b0;
    end
  end

  assign bus_error = !live;
  assign stall_inc = !reset & live & !pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_src),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
// random traffic compared each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          ex_memRead = 1'b0;
  logic          mem_branch = 1'b0, mem_zero = 1'b0;
  logic          mem_lessThan = 1'b0;
  logic [3:0]    mem_funct = '0;
  logic          mem_memRead = 1'b0, mem_memWrite = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          dmem_req;
  logic          pc_write, pc_src, ifid_write, ifid_flush;
  logic          idex_write, idex_flush, exmem_write;
  logic          exmem_flush, memwb_flush, bus_error;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_lessThan(mem_lessThan), .mem_funct(mem_funct),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .bus_error(bus_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: waiting on memory, not-ready cycles seen, error latched
  bit m_wait, m_err, n_wait, n_err;
  int m_waits, m_sc, m_fc, n_waits, n_sc, n_fc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int act_vec();
    return {pc_write, pc_src, ifid_write, ifid_flush,
            idex_write, idex_flush, exmem_write, exmem_flush,
            memwb_flush, dmem_req, bus_error};
  endfunction

  task automatic settle();
    bit pw, ps, iw, ifl, xw, xfl, ew, efl, wfl, rq, be;
    bit acc, stl, tk, lu;
    int f3;
    #1;
    if (reset) begin
      m_wait = 0; m_err = 0; m_waits = 0; m_sc = 0; m_fc = 0;
    end
    f3  = int'(mem_funct) % 8;
    acc = mem_memRead || mem_memWrite;
    stl = !m_err && acc && !dmem_ready;
    tk  = mem_branch && ((f3 == 0 && mem_zero) ||
          (f3 == 1 && !mem_zero) || (f3 == 4 && mem_lessThan) ||
          (f3 == 5 && !mem_lessThan));
    lu  = ex_memRead && ex_rd != 0 &&
          (ex_rd == id_rs1 || ex_rd == id_rs2);
    {pw, iw, xw, ew} = 4'b1111;
    {ps, ifl, xfl, efl, wfl} = 5'b0;
    rq = !m_err && acc;
    be = m_err;
    if (reset) begin
      {pw, iw, xw, ew, ps, rq} = 6'b0;
      {ifl, xfl, efl, wfl} = 4'b1111;
    end else if (m_err || stl) begin
      {pw, iw, xw, ew} = 4'b0;
      wfl = 1;
    end else if (tk) begin
      {ps, ifl, xfl, efl} = 4'b1111;
    end else if (lu) begin
      pw = 0; iw = 0; xfl = 1;
    end
    chk("ctrl", act_vec(),
        {pw, ps, iw, ifl, xw, xfl, ew, efl, wfl, rq, be});
    chk("stall_cycles", int'(stall_cycles), m_sc);
    chk("flush_count", int'(flush_count), m_fc);
    n_wait = m_wait; n_err = m_err; n_waits = m_waits;
    n_sc = m_sc; n_fc = m_fc;
    if (reset) begin
      n_wait = 0; n_err = 0; n_waits = 0; n_sc = 0; n_fc = 0;
    end else if (!m_err) begin
      if (m_wait) begin
        if (dmem_ready) n_wait = 0;
        else begin
          n_waits = m_waits + 1;
          if (n_waits == TO) begin n_err = 1; n_wait = 0; end
        end
      end else if (stl) begin
        n_wait = 1; n_waits = 0;
      end
      if (!pw && m_sc < CMAX) n_sc = m_sc + 1;
    end
    if (ps && m_fc < CMAX) n_fc = m_fc + 1;
  endtask

  task automatic adv();
    @(posedge clk);
    m_wait = n_wait; m_err = n_err; m_waits = n_waits;
    m_sc = n_sc; m_fc = n_fc;
    @(negedge clk);
  endtask

  task automatic clr_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memRead = 0;
    mem_branch = 0; mem_zero = 0; mem_lessThan = 0; mem_funct = 0;
    mem_memRead = 0; mem_memWrite = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    settle();
    chk("rst_dmem_req", int'(dmem_req), 0);
    chk("rst_ifid_flush", int'(ifid_flush), 1);
    chk("rst_stall_cnt", int'(stall_cycles), 0);
    adv();
    reset = 0;
    clr_in();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    settle();
    chk("idle_pc_write", int'(pc_write), 1);
    adv();

    // load-use on rs2
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 3;
    settle();
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_ifid_write", int'(ifid_write), 0);
    chk("lu_idex_flush", int'(idex_flush), 1);
    adv();
    ex_memRead = 0;
    settle();
    chk("lu_done_pc_write", int'(pc_write), 1);
    chk("lu_stall_cnt", int'(stall_cycles), 1);
    adv();
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    settle();
    chk("lu_x0_pc_write", int'(pc_write), 1);
    adv();
    clr_in();

    // beq taken / not taken
    do_reset();
    mem_branch = 1; mem_funct = 4'b0000; mem_zero = 1;
    settle();
    chk("beq_pc_src", int'(pc_src), 1);
    chk("beq_exmem_flush", int'(exmem_flush), 1);
    chk("beq_fc_before", int'(flush_count), 0);
    adv();
    mem_zero = 0;
    settle();
    chk("beq_nt_flush", int'(ifid_flush), 0);
    chk("beq_fc_after", int'(flush_count), 1);
    adv();
    clr_in();

    // memory wait: 3 not-ready cycles then ready
    do_reset();
    mem_memRead = 1;
    repeat (3) begin
      settle();
      chk("mw_frozen", int'(pc_write), 0);
      adv();
    end
    dmem_ready = 1;
    settle();
    chk("mw_release", int'(pc_write), 1);
    adv();
    clr_in();
    settle();
    chk("mw_stall_cnt", int'(stall_cycles), 3);
    adv();

    // timeout to bus error
    do_reset();
    mem_memRead = 1;
    for (int i = 0; i < 17; i++) begin
      settle();
      if (i == 16) chk("to_no_err_yet", int'(bus_error), 0);
      adv();
    end
    settle();
    chk("to_bus_error", int'(bus_error), 1);
    chk("to_dmem_req", int'(dmem_req), 0);
    chk("to_memwb_flush", int'(memwb_flush), 1);
    adv();
    dmem_ready = 1;
    settle();
    chk("to_sticky", int'(bus_error), 1);
    adv();
    do_reset();
    settle();
    chk("to_cleared", int'(bus_error), 0);
    adv();

    // branch and load-use together
    mem_branch = 1; mem_funct = 4'b1101; mem_lessThan = 0;
    ex_memRead = 1; ex_rd = 7; id_rs1 = 7;
    settle();
    chk("sim_pc_write", int'(pc_write), 1);
    chk("sim_pc_src", int'(pc_src), 1);
    chk("sim_ifid_write", int'(ifid_write), 1);
    adv();
    clr_in();

    // counter saturation
    do_reset();
    ex_memRead = 1; ex_rd = 9; id_rs1 = 9;
    repeat (20) begin settle(); adv(); end
    clr_in();
    settle();
    chk("sat_stall_cnt", int'(stall_cycles), 15);
    adv();

    // reset mid-wait drops the request immediately
    do_reset();
    mem_memWrite = 1;
    settle(); adv();
    settle();
    chk("mid_req_before", int'(dmem_req), 1);
    #2 reset = 1;
    #1 chk("mid_req_async", int'(dmem_req), 0);
    settle(); adv();
    reset = 0;
    clr_in();

    // random traffic
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0 ||
          (m_err && $urandom_range(0, 3) == 0))
        do_reset();
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      ex_rd      = 5'($urandom_range(0, 3));
      ex_memRead = 1'($urandom_range(0, 1));
      if (!m_wait) begin
        mem_branch   = 1'($urandom_range(0, 1));
        mem_zero     = 1'($urandom_range(0, 1));
        mem_lessThan = 1'($urandom_range(0, 1));
        mem_funct    = 4'($urandom);
        mem_memRead  = ($urandom_range(0, 3) == 0);
        mem_memWrite = ($urandom_range(0, 5) == 0);
      end
      dmem_ready = ($urandom_range(0, 2) != 0);
      settle();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
